dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Controller that shares the single-port data memory (10-bit word address, 32-bit data, writes and read-address capture on the memory's falling clock edge) between the CPU load/store path and a DMA burst engine. The CPU path issues single accesses. The DMA path is sequenced internally from a base address and length. The block sits directly in front of the data memory, owns its write-enable and read-enable controls, and returns read data to whichever side issued each access.

## Interface
- ADDR_W, 10, word address width (memory depth 2^ADDR_W)
- DATA_W, 32, data word width
- LEN_W, 11, DMA length width (max burst 1024 words)
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request, held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  combinational; CPU access granted this cycle
- cpu_rvalid  out  1  CPU read data valid (one-cycle pulse)
- cpu_rdata  out  DATA_W  CPU read data
- dma_start  in  1  start burst; ignored while dma_busy
- dma_write  in  1  burst direction: 1 = write to memory
- dma_base  in  ADDR_W  burst start address
- dma_len  in  LEN_W  number of beats, 0..1024
- dma_wdata  in  DATA_W  DMA write data, sampled when dma_wpop = 1
- dma_wpop  out  1  combinational; DMA write beat granted, consumes dma_wdata
- dma_rvalid  out  1  DMA read beat valid
- dma_rdata  out  DATA_W  DMA read data
- dma_busy  out  1  burst in progress, including drain
- dma_done  out  1  one-cycle pulse at burst completion
- mem_addr  out  ADDR_W  registered memory address
- mem_wdata  out  DATA_W  registered memory write data
- mem_we  out  1  registered memory write enable
- mem_re  out  1  registered memory read enable
- mem_rdata  in  DATA_W  memory read output

## Operation
- DMA FSM states: D_IDLE, D_RUN, D_DRAIN.
  - D_IDLE: on dma_start, latch base, length and direction. If dma_len = 0, stay in D_IDLE and pulse dma_done in the next cycle; no memory access occurs. Otherwise go to D_RUN and set dma_busy.
  - D_RUN: each granted DMA beat increments the address (wrapping from 2^ADDR_W-1 to 0) and decrements the remaining count. When the last beat is granted, go to D_DRAIN.
  - D_DRAIN: wait 2 cycles for the last beat to complete, pulse dma_done, return to D_IDLE, clear dma_busy.
- Slot selection in each cycle:
  - The CPU wins when cpu_req = 1, unless the FSM is in D_RUN and the previous slot went to the CPU. In that case the DMA wins, which guarantees the DMA at least 1 beat per 2 cycles.
  - With no CPU request and the FSM in D_RUN, the DMA wins every cycle.
  - With no winner, the next cycle has mem_we = mem_re = 0 and mem_addr/mem_wdata hold their values.
- The grant registers mem_addr, mem_wdata, mem_we (write) or mem_re (read). A tag records the owner for response routing.
- Accesses complete in grant order. A CPU write and a DMA read to the same address are ordered by slot, with no forwarding.
- The block performs no address checking; the full address space is legal.

## Timing
- Grant in cycle k → memory command driven in cycle k+1. The memory captures it on the falling edge of k+1. mem_rdata is sampled at the end of k+1, and rvalid/rdata are presented in cycle k+2.
- Throughput: 1 access per cycle, back-to-back, with no bubbles.
- dma_done pulses in cycle k+2 for the last beat's grant cycle k, for both directions. dma_done coincides with the final dma_rvalid.
- A new dma_start is accepted in the cycle after dma_done.
- Reset values: every output is 0 (including mem_we, mem_re, mem_addr, mem_wdata, rvalid/rdata, dma_busy, dma_done); the FSM is in D_IDLE; the fairness flag is cleared.
- Reset mid-burst: the burst is abandoned, no dma_done pulse, and in-flight responses are dropped.
- dma_start asserted while dma_busy: ignored, with no side effects.

## Structure
- Shared package dmem_pkg holds ADDR_W/DATA_W/LEN_W defaults, the D_IDLE/D_RUN/D_DRAIN state encoding, and the owner tag encoding (OWN_NONE, OWN_CPU, OWN_DMA).
- One sub-module, dmem_slot_sel: the combinational CPU/DMA winner choice plus the registered fairness flag.
- The FSM, address counter and response pipeline stay in the top module.

## Test plan
- CPU write 0x0000_000C to address 5, then read address 5 → mem_we pulses in cycle k+1; the read returns cpu_rvalid with 0x0000_000C two cycles after its grant.
- DMA write burst: base 1020, len 8, CPU idle → 8 consecutive mem_we cycles with addresses 1020..1023, 0..3 and dma_wpop high for 8 cycles; dma_done pulses 2 cycles after the last grant.
- DMA read burst of len 4 with cpu_req held high continuously → slots alternate CPU/DMA; all 4 dma_rvalid beats arrive within 8 cycles; cpu_ready is never low for 2 consecutive cycles.
- dma_len = 0 → dma_done pulses the cycle after dma_start; mem_we and mem_re stay 0; dma_busy stays 0.
- dma_start while busy, then reset asserted mid-burst → the second start is ignored; after reset all outputs are 0 and no dma_done is seen.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: width defaults,
// DMA sequencer state encoding and response-owner tags.
package dmem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 11;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_RUN   = 2'd1,
    D_DRAIN = 2'd2
  } dmaState_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_slot_sel.sv
// Per-cycle memory slot winner between the CPU port and the DMA sequencer.
// A fairness flag remembers whether the previous slot went to the CPU so a
// running burst is never starved for more than one cycle.
module dmem_slot_sel
  import dmem_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic cpuReq,
  input  logic dmaReq,
  output logic cpuWin,
  output logic dmaWin
);

  logic lastCpu;

  // CPU has priority except right after its own slot while a burst runs
  always_comb begin
    cpuWin = cpuReq && !(dmaReq && lastCpu);
    dmaWin = dmaReq && !cpuWin;
  end

  // Track who owned the slot just granted; an empty slot clears the flag
  always_ff @(posedge clock) begin
    if (!reset) lastCpu <= 1'b0;
    else        lastCpu <= cpuWin;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Front-end for the single-port data memory. Grants one access per cycle to
// either the CPU or the internal DMA burst sequencer, registers the memory
// command, and routes read data back to the issuer two cycles after grant.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_start,
  input  logic              dma_write,
  input  logic [ADDR_W-1:0] dma_base,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_wpop,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  dmaState_t         state;
  logic [ADDR_W-1:0] dmaAddr;
  logic [LEN_W-1:0]  dmaRem;
  logic              dmaDir;
  logic              drainCnt;
  owner_t            memOwn;
  logic              cpuWin;
  logic              dmaWin;
  logic              startOk;

  // Starts are taken only from idle, and not in the done-pulse cycle
  assign startOk = dma_start && (state == D_IDLE) && !dma_done;

  dmem_slot_sel uSlotSel (
    .clock  (clock),
    .reset  (reset),
    .cpuReq (cpu_req),
    .dmaReq (state == D_RUN),
    .cpuWin (cpuWin),
    .dmaWin (dmaWin)
  );

  assign cpu_ready = cpuWin;
  assign dma_wpop  = dmaWin && dmaDir;

  // DMA sequencer: latch burst, count beats, drain two cycles, pulse done
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= D_IDLE;
      dmaAddr  <= '0;
      dmaRem   <= '0;
      dmaDir   <= 1'b0;
      drainCnt <= 1'b0;
      dma_busy <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      case (state)
        D_IDLE: begin
          if (startOk) begin
            dmaAddr <= dma_base;
            dmaRem  <= dma_len;
            dmaDir  <= dma_write;
            if (dma_len == '0) begin
              dma_done <= 1'b1;
            end else begin
              state    <= D_RUN;
              dma_busy <= 1'b1;
            end
          end
        end
        D_RUN: begin
          if (dmaWin) begin
            dmaAddr <= dmaAddr + 1'b1;
            dmaRem  <= dmaRem - 1'b1;
            if (dmaRem == LEN_W'(1)) begin
              state    <= D_DRAIN;
              drainCnt <= 1'b0;
            end
          end
        end
        D_DRAIN: begin
          // done lands in the cycle the final read response is presented
          if (!drainCnt) begin
            drainCnt <= 1'b1;
            dma_done <= 1'b1;
          end else begin
            state    <= D_IDLE;
            dma_busy <= 1'b0;
          end
        end
        default: state <= D_IDLE;
      endcase
    end
  end

  // Register the granted command; empty slots hold address and data
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      memOwn    <= OWN_NONE;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      memOwn <= OWN_NONE;
      if (cpuWin) begin
        mem_addr <= cpu_addr;
        mem_we   <= cpu_we;
        mem_re   <= !cpu_we;
        memOwn   <= OWN_CPU;
        if (cpu_we) mem_wdata <= cpu_wdata;
      end else if (dmaWin) begin
        mem_addr <= dmaAddr;
        mem_we   <= dmaDir;
        mem_re   <= !dmaDir;
        memOwn   <= OWN_DMA;
        if (dmaDir) mem_wdata <= dma_wdata;
      end
    end
  end

  // Capture memory read data and steer it to the owner of that slot
  always_ff @(posedge clock) begin
    if (!reset) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      cpu_rvalid <= mem_re && (memOwn == OWN_CPU);
      dma_rvalid <= mem_re && (memOwn == OWN_DMA);
      if (mem_re && (memOwn == OWN_CPU)) cpu_rdata <= mem_rdata;
      if (mem_re && (memOwn == OWN_DMA)) dma_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a falling-edge single-port memory model.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_start;
  logic        dma_write;
  logic [9:0]  dma_base;
  logic [10:0] dma_len;
  logic [31:0] dma_wdata;
  logic        dma_wpop;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_busy;
  logic        dma_done;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  bit expRdy  [11] = '{1,0,1,0,1,0,1,0,1,1,1};
  bit expDv   [11] = '{0,0,0,1,0,1,0,1,0,1,0};
  bit expCv   [11] = '{0,0,1,0,1,0,1,0,1,0,1};
  bit expDone [11] = '{0,0,0,0,0,0,0,0,0,1,0};
  bit expBusy [11] = '{0,1,1,1,1,1,1,1,1,1,0};

  dmem_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_start  (dma_start),
    .dma_write  (dma_write),
    .dma_base   (dma_base),
    .dma_len    (dma_len),
    .dma_wdata  (dma_wdata),
    .dma_wpop   (dma_wpop),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .dma_busy   (dma_busy),
    .dma_done   (dma_done),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory captures writes and read address on the falling edge
  always @(negedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] ea;
    int lowPairs, dvCount, beat;
    bit prevLow, sawDone, sawAct;

    reset = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_start = 0; dma_write = 0; dma_base = '0; dma_len = '0; dma_wdata = '0;
    repeat (3) step();

    // reset state
    check("rst_we", mem_we, 0);
    check("rst_re", mem_re, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_busy", dma_busy, 0);
    check("rst_done", dma_done, 0);
    check("rst_rv", {cpu_rvalid, dma_rvalid}, 0);
    check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    reset = 1'b1;
    step();

    // CPU write 0xC to address 5, then read it back
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'd5; cpu_wdata = 32'h0000_000C;
    #1 check("cpu_wr_ready", cpu_ready, 1);
    step();
    cpu_req = 0;
    #1;
    check("cpu_wr_we", mem_we, 1);
    check("cpu_wr_re", mem_re, 0);
    check("cpu_wr_addr", mem_addr, 5);
    check("cpu_wr_data", mem_wdata, 32'hC);
    step();
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'd5;
    #1;
    check("cpu_rd_ready", cpu_ready, 1);
    check("idle_slot_we", mem_we, 0);
    step();
    cpu_req = 0;
    #1;
    check("cpu_rd_re", mem_re, 1);
    check("cpu_rd_addr", mem_addr, 5);
    check("cpu_rd_hold_wdata", mem_wdata, 32'hC);
    check("cpu_rv_early", cpu_rvalid, 0);
    step();
    check("cpu_rv", cpu_rvalid, 1);
    check("cpu_rdata", cpu_rdata, 32'hC);
    step();
    check("cpu_rv_pulse", cpu_rvalid, 0);

    // DMA write burst, base 1020, len 8, wraps past 1023
    dma_start = 1; dma_write = 1; dma_base = 10'd1020; dma_len = 11'd8;
    #1;
    check("dw_idle_wpop", dma_wpop, 0);
    check("dw_idle_busy", dma_busy, 0);
    step();
    dma_start = 0;
    for (int i = 0; i < 8; i++) begin
      dma_wdata = 32'hD000_0000 + i;
      #1;
      check("dw_wpop", dma_wpop, 1);
      check("dw_busy", dma_busy, 1);
      if (i == 0) begin
        check("dw_first_we", mem_we, 0);
      end else begin
        ea = 10'(1020 + i - 1);
        check("dw_we", mem_we, 1);
        check("dw_addr", mem_addr, ea);
        check("dw_data", mem_wdata, 32'hD000_0000 + i - 1);
      end
      step();
    end
    #1;
    check("dw_end_wpop", dma_wpop, 0);
    check("dw_last_we", mem_we, 1);
    check("dw_last_addr", mem_addr, 3);
    check("dw_last_data", mem_wdata, 32'hD000_0007);
    check("dw_done_early", dma_done, 0);
    step();
    check("dw_done", dma_done, 1);
    check("dw_done_we", mem_we, 0);
    check("dw_done_busy", dma_busy, 1);
    step();
    check("dw_done_pulse", dma_done, 0);
    check("dw_busy_clr", dma_busy, 0);
    check("dw_mem1023", mem[1023], 32'hD000_0003);
    check("dw_mem0", mem[0], 32'hD000_0004);

    // DMA read burst len 4 with CPU requesting every cycle
    lowPairs = 0; dvCount = 0; beat = 0; prevLow = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'd5;
    for (int c = 0; c < 11; c++) begin
      if (c == 0) begin
        dma_start = 1; dma_write = 0; dma_base = 10'd1020; dma_len = 11'd4;
      end else begin
        dma_start = 0;
      end
      #1;
      check($sformatf("dr_ready_c%0d", c), cpu_ready, expRdy[c]);
      check($sformatf("dr_dv_c%0d", c), dma_rvalid, expDv[c]);
      check($sformatf("dr_cv_c%0d", c), cpu_rvalid, expCv[c]);
      check($sformatf("dr_done_c%0d", c), dma_done, expDone[c]);
      check($sformatf("dr_busy_c%0d", c), dma_busy, expBusy[c]);
      if (expDv[c]) begin
        check($sformatf("dr_data_b%0d", beat), dma_rdata, 32'hD000_0000 + beat);
        beat++;
      end
      if (expCv[c]) check("dr_cpu_data", cpu_rdata, 32'hC);
      if (dma_rvalid) dvCount++;
      if (!cpu_ready && prevLow) lowPairs++;
      prevLow = !cpu_ready;
      step();
    end
    check("dr_beats", dvCount, 4);
    check("dr_no_starve", lowPairs, 0);
    cpu_req = 0;
    repeat (4) step();

    // zero-length burst
    dma_start = 1; dma_write = 1; dma_base = 10'd7; dma_len = 11'd0;
    #1 check("z_busy0", dma_busy, 0);
    step();
    dma_start = 0;
    #1;
    check("z_done", dma_done, 1);
    check("z_busy", dma_busy, 0);
    check("z_memctl", {mem_we, mem_re}, 0);
    check("z_wpop", dma_wpop, 0);
    step();
    check("z_done_pulse", dma_done, 0);
    check("z_memctl2", {mem_we, mem_re, dma_busy}, 0);

    // start while busy is ignored, then reset mid-burst
    dma_start = 1; dma_write = 1; dma_base = 10'd0; dma_len = 11'd8; dma_wdata = 32'h5555_AAAA;
    step();
    dma_start = 0;
    #1;
    check("b_busy", dma_busy, 1);
    check("b_wpop", dma_wpop, 1);
    step();
    dma_start = 1; dma_base = 10'd500; dma_len = 11'd2; dma_write = 0;
    #1;
    check("b_ign_wpop", dma_wpop, 1);
    check("b_addr0", mem_addr, 0);
    check("b_we0", mem_we, 1);
    step();
    dma_start = 0;
    #1;
    check("b_addr1", mem_addr, 1);
    check("b_we1", {mem_we, mem_re}, 2'b10);
    check("b_busy1", dma_busy, 1);
    reset = 1'b0;
    step();
    check("mr_memctl", {mem_we, mem_re}, 0);
    check("mr_addr", mem_addr, 0);
    check("mr_wdata", mem_wdata, 0);
    check("mr_dma", {dma_busy, dma_done, dma_wpop, dma_rvalid}, 0);
    check("mr_cpu", {cpu_ready, cpu_rvalid}, 0);
    check("mr_rdata", {cpu_rdata, dma_rdata}, 0);
    step();
    reset = 1'b1;
    sawDone = 0; sawAct = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (dma_done) sawDone = 1;
      if (mem_we || mem_re || dma_busy || dma_rvalid) sawAct = 1;
    end
    check("mr_no_done", sawDone, 0);
    check("mr_no_activity", sawAct, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
